stripes_bit_serializer: RTL and testbench

Front-end sequencer for the Stripes-style bit-serial MAC. It accepts one job per handshake: an activation vector, a signed weight vector, an accumulator seed and a chain flag. It then streams the weights MSB-first as one bit-column per cycle, together with the shift index, the MSB (negate) flag, the MAC enable and the accumulator-load controls. It also flags the cycle in which the downstream accumulator holds a finished dot product.

---
 rtl/stripes_bit_serializer.sv | 219 +++++++++++++++++++++
 tb/tb_stripes_bit_serializer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stripes_bit_serializer.sv
// -----------------------------------------------------------------------------
// stripes_bit_serializer
//
// Front-end sequencer for a Stripes-style bit-serial MAC. It accepts one job
// per valid/ready handshake: an activation vector, a signed weight vector, an
// accumulator seed and a chain flag. It then streams the weights MSB-first,
// one bit column per cycle. Each column is presented with its shift index,
// the sign-column flag, the MAC enable and the accumulator-load control.
// result_valid marks the cycle in which the downstream accumulator holds a
// finished dot product.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high; clears all state
//   in_valid       in   job offered
//   in_ready       out  job can be accepted this cycle
//   in_act         in   DATA_WIDTH x VEC_LENGTH signed activations (lane j at [j*DW +: DW])
//   in_w           in   DATA_WIDTH x VEC_LENGTH signed weights     (lane j at [j*DW +: DW])
//   in_accum_init  in   accumulator seed
//   in_chain       in   1 = continue on previous accumulator, seed ignored
//   act            out  activations of the active job
//   w_bit          out  current weight bit per lane
//   column_idx     out  bit position of the current column
//   is_msb         out  current column is the sign column
//   en             out  MAC advance
//   load_accum     out  MAC takes accum_prev instead of its feedback
//   accum_prev     out  registered seed of the active job
//   result_valid   out  one-cycle pulse: MAC accumulator holds a completed job
// -----------------------------------------------------------------------------
module stripes_bit_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int ACC_WIDTH  = DATA_WIDTH + 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0] in_act,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0] in_w,
    input  logic [ACC_WIDTH-1:0]             in_accum_init,
    input  logic                             in_chain,
    output logic [DATA_WIDTH*VEC_LENGTH-1:0] act,
    output logic [VEC_LENGTH-1:0]            w_bit,
    output logic [$clog2(DATA_WIDTH)-1:0]    column_idx,
    output logic                             is_msb,
    output logic                             en,
    output logic                             load_accum,
    output logic [ACC_WIDTH-1:0]             accum_prev,
    output logic                             result_valid
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int VW = DATA_WIDTH * VEC_LENGTH;

    // Column indices of the sign column and of the column after it; the seed
    // is loaded in the latter because the MAC adds each partial sum one cycle
    // after the column is issued.
    localparam logic [CW-1:0] C_MSB  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] C_SEED = CW'(DATA_WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    // FSM and column counter
    state_e               state_q, state_d;
    logic [CW-1:0]        c_q, c_d;

    // Job register
    logic [VW-1:0]        job_act_q, job_act_d;
    logic [VW-1:0]        job_w_q, job_w_d;
    logic [ACC_WIDTH-1:0] job_seed_q, job_seed_d;
    logic                 job_chain_q, job_chain_d;

    // Marks the cycle that adds the last partial sum of a job into the MAC
    logic                 complete_q, complete_d;

    // Registered column outputs
    logic [VEC_LENGTH-1:0] w_bit_q, w_bit_d;
    logic [CW-1:0]         column_idx_q, column_idx_d;
    logic                  is_msb_q, is_msb_d;
    logic                  en_q, en_d;
    logic                  load_accum_q, load_accum_d;
    logic                  result_valid_q, result_valid_d;

    logic                  accept;

    // Ready decodes from registered state only: never mid-job, except on the
    // last column so back-to-back jobs run without a bubble.
    assign in_ready = (state_q != S_RUN) || (c_q == '0);
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        job_act_d   = job_act_q;
        job_w_d     = job_w_q;
        job_seed_d  = job_seed_q;
        job_chain_d = job_chain_q;
        complete_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    c_d     = C_MSB;
                end
            end
            S_RUN: begin
                if (c_q == '0) begin
                    // The following en cycle adds this column's partial sum,
                    // whether it is a DRAIN or the next job's first column.
                    complete_d = 1'b1;
                    if (accept) begin
                        state_d = S_RUN;
                        c_d     = C_MSB;
                    end else begin
                        state_d = S_DRAIN;
                        c_d     = '0;
                    end
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    state_d = S_RUN;
                    c_d     = C_MSB;
                end else begin
                    state_d = S_IDLE;
                    c_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                c_d     = '0;
            end
        endcase

        if (accept) begin
            job_act_d   = in_act;
            job_w_d     = in_w;
            job_seed_d  = in_accum_init;
            job_chain_d = in_chain;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so every output is a flop
    // -------------------------------------------------------------------------
    always_comb begin
        w_bit_d        = '0;
        column_idx_d   = '0;
        is_msb_d       = 1'b0;
        load_accum_d   = 1'b0;
        en_d           = (state_d != S_IDLE);
        result_valid_d = complete_q;

        if (state_d == S_RUN) begin
            column_idx_d = c_d;
            is_msb_d     = (c_d == C_MSB);
            load_accum_d = (c_d == C_SEED) && !job_chain_d;
            for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
                w_bit_d[j] = job_w_d[j*DATA_WIDTH + c_d];
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            c_q            <= '0;
            job_act_q      <= '0;
            job_w_q        <= '0;
            job_seed_q     <= '0;
            job_chain_q    <= 1'b0;
            complete_q     <= 1'b0;
            w_bit_q        <= '0;
            column_idx_q   <= '0;
            is_msb_q       <= 1'b0;
            en_q           <= 1'b0;
            load_accum_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            c_q            <= c_d;
            job_act_q      <= job_act_d;
            job_w_q        <= job_w_d;
            job_seed_q     <= job_seed_d;
            job_chain_q    <= job_chain_d;
            complete_q     <= complete_d;
            w_bit_q        <= w_bit_d;
            column_idx_q   <= column_idx_d;
            is_msb_q       <= is_msb_d;
            en_q           <= en_d;
            load_accum_q   <= load_accum_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign act          = job_act_q;
    assign accum_prev   = job_seed_q;
    assign w_bit        = w_bit_q;
    assign column_idx   = column_idx_q;
    assign is_msb       = is_msb_q;
    assign en           = en_q;
    assign load_accum   = load_accum_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_stripes_bit_serializer.sv
// -----------------------------------------------------------------------------
// Bench for stripes_bit_serializer. A behavioural bit-serial MAC is attached
// to the outputs; expected results come from plain dot-product arithmetic and
// expected per-cycle outputs from the job timing (column c = 7 - cycles since
// accept, one drain cycle after the last column, result two cycles later).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stripes_bit_serializer;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int AW = DW + 16;
    localparam int VW = DW * VL;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_act;
    logic [VW-1:0] in_w;
    logic [AW-1:0] in_accum_init;
    logic          in_chain;
    logic [VW-1:0] act;
    logic [VL-1:0] w_bit;
    logic [2:0]    column_idx;
    logic          is_msb;
    logic          en;
    logic          load_accum;
    logic [AW-1:0] accum_prev;
    logic          result_valid;

    stripes_bit_serializer #(
        .DATA_WIDTH(DW),
        .VEC_LENGTH(VL),
        .ACC_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_act       (in_act),
        .in_w         (in_w),
        .in_accum_init(in_accum_init),
        .in_chain     (in_chain),
        .act          (act),
        .w_bit        (w_bit),
        .column_idx   (column_idx),
        .is_msb       (is_msb),
        .en           (en),
        .load_accum   (load_accum),
        .accum_prev   (accum_prev),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    longint cyc  = 0;

    // ---------------- behavioural MAC attached downstream ----------------
    longint mac_ps;
    longint mac_acc;

    function automatic longint column_sum();
        longint s;
        s = 0;
        for (int j = 0; j < VL; j++)
            if (w_bit[j]) s += longint'($signed(act[j*DW +: DW]));
        if (is_msb) s = -s;
        return s * (longint'(1) << column_idx);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_ps  <= 0;
            mac_acc <= 0;
        end else if (en) begin
            mac_acc <= (load_accum ? longint'($signed(accum_prev)) : mac_acc) + mac_ps;
            mac_ps  <= column_sum();
        end
    end

    // ---------------- reference model state ----------------
    longint        last_e;
    logic [VW-1:0] last_act;
    logic [VW-1:0] last_w;
    logic [AW-1:0] last_seed;
    bit            last_chain;
    longint        model_acc;
    longint        due_q[$];
    longint        res_q[$];

    task automatic clear_model();
        last_e     = -1000;
        last_act   = '0;
        last_w     = '0;
        last_seed  = '0;
        last_chain = 1'b0;
        model_acc  = 0;
        due_q.delete();
        res_q.delete();
    endtask

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        longint        off;
        longint        r;
        int            c;
        bit            e_en, e_msb, e_load, e_ready, e_rv;
        logic [VL-1:0] e_wb;
        int            e_col;
        off    = cyc - last_e;
        e_en   = 1'b0;
        e_msb  = 1'b0;
        e_load = 1'b0;
        e_wb   = '0;
        e_col  = 0;
        if (off >= 0 && off < DW) begin
            c      = DW - 1 - int'(off);
            e_en   = 1'b1;
            e_col  = c;
            e_msb  = (c == DW - 1);
            e_load = (c == DW - 2) && !last_chain;
            for (int j = 0; j < VL; j++) e_wb[j] = last_w[j*DW + c];
        end else if (off == DW) begin
            e_en = 1'b1;
        end
        e_ready = !(off >= 0 && off < DW - 1);
        e_rv    = (due_q.size() > 0) && (due_q[0] == cyc);

        check("en",          longint'(en),          longint'(e_en));
        check("is_msb",      longint'(is_msb),      longint'(e_msb));
        check("load_accum",  longint'(load_accum),  longint'(e_load));
        check("column_idx",  longint'(column_idx),  longint'(e_col));
        check("w_bit",       longint'(w_bit),       longint'(e_wb));
        check("in_ready",    longint'(in_ready),    longint'(e_ready));
        check("result_valid",longint'(result_valid),longint'(e_rv));
        check("act_held",    longint'(act == last_act), 1);
        check("accum_prev",  longint'(accum_prev),  longint'(last_seed));

        if (e_rv) begin
            r = res_q[0];
            check("mac_result", longint'(mac_acc[AW-1:0]), longint'(r[AW-1:0]));
            void'(due_q.pop_front());
            void'(res_q.pop_front());
        end
    endtask

    // One clock: note a handshake before the edge, update the model, check.
    task automatic tick(output bit accepted);
        logic [VW-1:0] a_s, w_s;
        logic [AW-1:0] s_s;
        bit            ch_s;
        longint        dot;
        accepted = in_valid && in_ready;
        a_s  = in_act;
        w_s  = in_w;
        s_s  = in_accum_init;
        ch_s = in_chain;
        @(posedge clk);
        #1;
        cyc++;
        if (accepted) begin
            dot = 0;
            for (int j = 0; j < VL; j++)
                dot += longint'($signed(a_s[j*DW +: DW])) * longint'($signed(w_s[j*DW +: DW]));
            model_acc = (ch_s ? model_acc : longint'($signed(s_s))) + dot;
            res_q.push_back(model_acc);
            due_q.push_back(cyc + DW + 1);
            last_e     = cyc;
            last_act   = a_s;
            last_w     = w_s;
            last_seed  = s_s;
            last_chain = ch_s;
        end
        monitor();
    endtask

    function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
        logic [VW-1:0] r;
        for (int j = 0; j < VL; j++) r[j*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int j = 0; j < VL; j++) r[j*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic scramble_inputs();
        in_act        = rand_vec();
        in_w          = rand_vec();
        in_accum_init = AW'($urandom);
        in_chain      = 1'($urandom);
    endtask

    // Hold the offer until it is taken (bounded), then present garbage.
    task automatic offer(input logic [VW-1:0] a, input logic [VW-1:0] w,
                         input logic [AW-1:0] s, input bit ch);
        bit acc;
        bit done;
        done          = 1'b0;
        in_valid      = 1'b1;
        in_act        = a;
        in_w          = w;
        in_accum_init = s;
        in_chain      = ch;
        for (int k = 0; k < 20 && !done; k++) begin
            tick(acc);
            done = acc;
        end
        if (!done) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick(acc);
    endtask

    task automatic check_outputs_cleared(input string tag);
        check({tag, "_en"},         longint'(en), 0);
        check({tag, "_w_bit"},      longint'(w_bit), 0);
        check({tag, "_column_idx"}, longint'(column_idx), 0);
        check({tag, "_is_msb"},     longint'(is_msb), 0);
        check({tag, "_load_accum"}, longint'(load_accum), 0);
        check({tag, "_result_vld"}, longint'(result_valid), 0);
        check({tag, "_act_zero"},   longint'(act == '0), 1);
        check({tag, "_accum_prev"}, longint'(accum_prev), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;
        int gap;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_act   = '0;
        in_w     = '0;
        in_accum_init = '0;
        in_chain = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_cleared("rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", longint'(in_ready), 1);

        // Single job act=1 w=1 -> 16, nine en cycles
        offer(fill(8'd1), fill(8'd1), '0, 1'b0);
        idle(12);
        check("job_ones_acc", mac_acc, 16);

        // act=3, w=-2 -> -96
        offer(fill(8'd3), fill(8'hFE), '0, 1'b0);
        idle(12);
        check("job_neg_acc", mac_acc, -96);

        // Seed 100 -> 116
        offer(fill(8'd1), fill(8'd1), AW'(100), 1'b0);
        idle(12);
        check("job_seed_acc", mac_acc, 116);

        // Back-to-back, second chained -> 16 then 32
        offer(fill(8'd1), fill(8'd1), '0, 1'b0);
        offer(fill(8'd1), fill(8'd1), AW'(555), 1'b1);
        idle(12);
        check("b2b_chain_acc", mac_acc, 32);

        // Two unchained jobs with an idle gap -> 16 and 16
        offer(fill(8'd1), fill(8'd1), '0, 1'b0);
        idle(14);
        offer(fill(8'd1), fill(8'd1), '0, 1'b0);
        idle(12);
        check("gap_acc", mac_acc, 16);

        // Asynchronous reset mid-job at column 4
        offer(fill(8'd1), fill(8'd1), AW'(7), 1'b0);
        k = 0;
        while (column_idx != 3'd4 && k < 20) begin
            tick(acc);
            k++;
        end
        check("reach_col4", longint'(column_idx), 4);
        #2 reset = 1'b1;
        #1;
        check_outputs_cleared("midrst");
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", longint'(in_ready), 1);
        idle(4);
        offer(fill(8'd1), fill(8'd1), '0, 1'b0);
        idle(12);
        check("post_rst_acc", mac_acc, 16);

        // Randomized jobs, random chaining and gaps (often back-to-back)
        for (int n = 0; n < 200; n++) begin
            offer(rand_vec(), rand_vec(), AW'($urandom), 1'($urandom_range(0, 1)));
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : 0;
            if (gap > 0) idle(gap);
        end
        idle(14);
        check("queue_drained", longint'(due_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
